regfile_arbiter: RTL
====================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, register width; ADDR_W, default 3, register index width (8 entries).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has an access pending.
REQ-005 req0_ready / req1_ready  output  1  access from requester N accepted this cycle.
REQ-006 req0_we / req1_we  input  1  1 = write, 0 = read.
REQ-007 req0_lock / req1_lock  input  1  keep the grant after this access (atomic read-modify-write).
REQ-008 req0_addr / req1_addr  input  ADDR_W  register index.
REQ-009 req0_wdata / req1_wdata  input  DATA_W  write data.
REQ-010 rsp0_valid / rsp1_valid  output  1  read data valid for requester N, one-cycle pulse.
REQ-011 rsp0_rdata / rsp1_rdata  output  DATA_W  registered read data.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_addr  output  ADDR_W  register-file address.
REQ-014 rf_wdata  output  DATA_W  register-file write data.
REQ-015 rf_rdata  input  DATA_W  combinational register-file read data for rf_addr.

Function
REQ-016 The block SHALL grant at most one access per cycle; an access is accepted when reqN_valid && reqN_ready.
REQ-017 reqN_ready SHALL be combinational from the valid inputs, state and priority pointer; it SHALL never be high for both requesters.
REQ-018 FSM states SHALL be RR, LOCK0 and LOCK1.
REQ-019 In RR with one valid request, that request SHALL be granted.
REQ-020 In RR with both requests valid, the requester selected by the priority pointer (prio, 1 bit) SHALL be granted.
REQ-021 After any accepted access in RR, prio SHALL point to the other requester.
REQ-022 In LOCKn, only requester n SHALL be granted, and prio SHALL NOT change.
REQ-023 In LOCKn the other requester's ready SHALL stay 0 even when requester n is idle.
REQ-024 Transitions: an accepted access with lock=1 SHALL go to LOCKn; an accepted access with lock=0 in LOCKn SHALL go to RR with prio = other requester.
REQ-025 LOCKn SHALL persist while requester n is not valid (no timeout).
REQ-026 During a grant, rf_addr, rf_wdata and rf_we (= granted reqN_we) SHALL mirror the granted requester in the same cycle.
REQ-027 With no grant, rf_we SHALL be 0 and rf_addr/rf_wdata SHALL hold 0.
REQ-028 Accepted read: rf_rdata SHALL be captured into rspN_rdata at that edge, with rspN_valid=1 for exactly the next cycle (latency 1).
REQ-029 rspN_rdata SHALL hold its value until the next read by N.
REQ-030 Accepted write: no response; the value SHALL be visible to a read accepted in any later cycle.
REQ-031 Back-to-back accesses, including alternating requesters, SHALL sustain one access per cycle with no bubble.
REQ-032 There is no response backpressure; rspN_valid SHALL pulse regardless of reqN_valid.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=RR; prio=0; rsp0_valid=rsp1_valid=0; rsp0_rdata=rsp1_rdata=0; rf_we=0; both ready=0.
REQ-034 Reset during LOCKn or a pending read response SHALL abort the lock and drop the response; no rf write SHALL occur while rst_n=0.
REQ-035 The first grant after reset release SHALL go to requester 0 if both requesters are valid.

Verification
REQ-036 Both requesters valid continuously, all reads, after reset -> grants alternate 0,1,0,1; each rspN_valid 1 cycle after its grant.
REQ-037 req0 writes 8'hA5 to r3, then req1 reads r3 -> rsp1_rdata=8'hA5, rsp1_valid pulses once.
REQ-038 req1 read r5 with lock=1, then write r5 with lock=0; req0 valid throughout -> req0_ready=0 through both req1 accesses, state returns to RR, next grant to req0.
REQ-039 Only req1 valid for 4 cycles -> 4 accepted accesses; rf_we tracks req1_we each cycle; req0_ready stays 0.
REQ-040 rst_n pulled low while in LOCK0 with a read response due -> no rsp0_valid pulse, state=RR, prio=0, rf_we=0 immediately.
REQ-041 Both requesters valid, req0 write r7=8'h3C, then req1 read r7 on the very next cycle -> rsp1_rdata=8'h3C.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-port register file.
// Round-robin grant with a lock that holds the grant for read-modify-write.
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [1:0] {RR, LOCK0, LOCK1} state_t;

  state_t state;
  logic   prio;
  logic   gnt0, gnt1;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      unique case (state)
        RR: begin
          if (req0_valid && (!req1_valid || !prio)) gnt0 = 1'b1;
          else if (req1_valid)                      gnt1 = 1'b1;
        end
        LOCK0:   gnt0 = req0_valid;
        LOCK1:   gnt1 = req1_valid;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    if (gnt0) begin
      rf_we    = req0_we;
      rf_addr  = req0_addr;
      rf_wdata = req0_wdata;
    end else if (gnt1) begin
      rf_we    = req1_we;
      rf_addr  = req1_addr;
      rf_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RR;
      prio       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= gnt0 && !req0_we;
      rsp1_valid <= gnt1 && !req1_we;
      if (gnt0 && !req0_we) rsp0_rdata <= rf_rdata;
      if (gnt1 && !req1_we) rsp1_rdata <= rf_rdata;
      // prio only moves on RR grants and on lock release.
      if (gnt0) begin
        state <= req0_lock ? LOCK0 : RR;
        if (state == RR || !req0_lock) prio <= 1'b1;
      end else if (gnt1) begin
        state <= req1_lock ? LOCK1 : RR;
        if (state == RR || !req1_lock) prio <= 1'b0;
      end
    end
  end

endmodule
